des_sbox_seq: RTL and testbench



---
 rtl/des_sbox_pkg.sv | 59 +++++
 rtl/des_sbox_lane.sv | 26 ++
 rtl/des_sbox_seq.sv | 155 +++++++++++++++
 tb/tb_des_sbox_seq.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_sbox_pkg.sv
// des_sbox_pkg: shared constants and helpers for the multi-cycle DES S-box unit.
//   - SBOX_ROWS : the eight FIPS 46-3 S-boxes, one 64-bit word per (box,row),
//                 addressed as {box[2:0], row[1:0]}; column 0 sits in the top nibble.
//   - P_TABLE   : the 32-entry DES P permutation (1-based source bit, MSB = bit 1).
//   - state_e   : FSM encoding shared by the top level.
//   - lanes_legal / p_permute : elaboration check and P permutation helper.
package des_sbox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [63:0] SBOX_ROWS [32] = '{
    // S1
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    // S2
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    // S3
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    // S4
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    // S5
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    // S6
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    // S7
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    // S8
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
  };

  localparam logic [5:0] P_TABLE [32] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // Only power-of-two lane counts that divide the eight boxes evenly are supported.
  function automatic bit lanes_legal(input int lanes);
    case (lanes)
      1, 2, 4, 8: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Output bit i (counted from the MSB, 1-based) takes input bit P_TABLE[i-1].
  function automatic logic [31:0] p_permute(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) begin
      y[31 - i] = x[32 - int'(P_TABLE[i])];
    end
    return y;
  endfunction

endpackage

// File: rtl/des_sbox_lane.sv
// des_sbox_lane: one combinational S-box lookup.
// Ports:
//   sel    [2:0] in  : box select, 0 = S1 .. 7 = S8
//   chunk  [5:0] in  : 6-bit input b5..b0; row = {b5,b0}, column = b4..b1
//   nibble [3:0] out : S-box output
module des_sbox_lane
  import des_sbox_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [5:0] chunk,
  output logic [3:0] nibble
);

  logic [1:0]  row_s;
  logic [3:0]  col_s;
  logic [63:0] word_s;

  // Select the table row word, then the column nibble (column 0 is the top nibble).
  always_comb begin
    row_s  = {chunk[5], chunk[0]};
    col_s  = chunk[4:1];
    word_s = SBOX_ROWS[{sel, row_s}];
    nibble = word_s[4 * (15 - int'(col_s)) +: 4];
  end

endmodule

// File: rtl/des_sbox_seq.sv
// des_sbox_seq: multi-cycle DES S1..S8 substitution with valid/ready handshakes.
// LANES boxes are looked up per cycle, so a block takes 8/LANES BUSY cycles.
// Optional feature: define DES_SBOX_PERM_EN to pass the result through the DES
// P permutation as it is registered into o_data (latency unchanged).
// Ports:
//   i_clk, i_rst_n    : clock (rising edge), asynchronous active-low reset
//   i_clear           : synchronous abort back to IDLE (o_data kept)
//   i_valid/o_ready   : input handshake, i_data[47:42] feeds S1 .. [5:0] feeds S8
//   o_valid/i_ready   : output handshake, o_data[31:28] = S1 .. [3:0] = S8
//   o_busy            : high while a block is in BUSY or DONE
module des_sbox_seq
  import des_sbox_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [47:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_busy
);

  localparam int         STEPS     = 8 / LANES;
  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  if (!lanes_legal(LANES)) begin : g_lanes_illegal
    $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
  end

  state_e      state_r, state_s;
  logic [2:0]  step_r, step_s;
  logic [47:0] data_r, data_s;
  logic [31:0] acc_r, acc_s;
  logic [31:0] result_s;
  logic [31:0] out_s;
  logic        load_s;

  logic [2:0]  box_s   [LANES];
  logic [5:0]  chunk_s [LANES];
  logic [3:0]  nib_s   [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign box_s[g]   = 3'((int'(step_r) * LANES) + g);
    assign chunk_s[g] = data_r[6 * (7 - int'(box_s[g])) +: 6];

    des_sbox_lane u_lane (
      .sel    (box_s[g]),
      .chunk  (chunk_s[g]),
      .nibble (nib_s[g])
    );
  end

  // Accumulator with this cycle's lane nibbles merged in; on the last step this
  // is the complete result, so o_data can be loaded without an extra cycle.
  always_comb begin
    result_s = acc_r;
    for (int k = 0; k < LANES; k++) begin
      result_s[4 * (7 - int'(box_s[k])) +: 4] = nib_s[k];
    end
  end

`ifdef DES_SBOX_PERM_EN
  assign out_s = p_permute(result_s);
`else
  assign out_s = result_s;
`endif

  // Next-state and datapath control; i_clear overrides every transition.
  always_comb begin
    state_s = state_r;
    step_s  = step_r;
    data_s  = data_r;
    acc_s   = acc_r;
    load_s  = 1'b0;
    if (i_clear) begin
      state_s = IDLE;
      step_s  = 3'd0;
      data_s  = 48'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            state_s = BUSY;
            data_s  = i_data;
            acc_s   = 32'd0;
            step_s  = 3'd0;
          end else begin
            state_s = IDLE;
          end
        end
        BUSY: begin
          acc_s = result_s;
          if (step_r == LAST_STEP) begin
            state_s = DONE;
            step_s  = 3'd0;
            load_s  = 1'b1;
          end else begin
            step_s = step_r + 3'd1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state_s = IDLE;
          end else begin
            state_s = DONE;
          end
        end
        default: begin
          state_s = IDLE;
          step_s  = 3'd0;
        end
      endcase
    end
  end

  // State, step counter, input hold register and accumulator.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      step_r  <= 3'd0;
      data_r  <= 48'd0;
      acc_r   <= 32'd0;
    end else begin
      state_r <= state_s;
      step_r  <= step_s;
      data_r  <= data_s;
      acc_r   <= acc_s;
    end
  end

  // Registered outputs decoded from the next state; o_data only loads on completion.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_data  <= 32'd0;
    end else begin
      o_ready <= (state_s == IDLE);
      o_valid <= (state_s == DONE);
      o_busy  <= (state_s != IDLE);
      if (load_s) begin
        o_data <= out_s;
      end else begin
        o_data <= o_data;
      end
    end
  end

endmodule

// File: tb/tb_des_sbox_seq.sv
// tb_des_sbox_seq: four instances (LANES = 1, 2, 4, 8) driven one at a time.
// A scoreboard queue receives the reference result at each input handshake and
// is checked at each output handshake; directed sequences cover latency,
// backpressure, clear and asynchronous reset.
module tb_des_sbox_seq;

  logic        clk;
  logic        rst_n;
  logic        clear_in  [4];
  logic        valid_in  [4];
  logic        ready_in  [4];
  logic [47:0] data_in   [4];
  logic        ready_out [4];
  logic        valid_out [4];
  logic        busy_out  [4];
  logic [31:0] data_out  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_seq #(.LANES(1 << g)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clear (clear_in[g]),
      .i_valid (valid_in[g]),
      .o_ready (ready_out[g]),
      .i_data  (data_in[g]),
      .o_valid (valid_out[g]),
      .i_ready (ready_in[g]),
      .o_data  (data_out[g]),
      .o_busy  (busy_out[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // FIPS 46-3 S-boxes, box-major then row-major, decimal.
  int sbox_ref [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  int ptab [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur      = 0;
  int          cyc      = 0;
  int          last_acc = 0;
  int          gap      = 0;
  bit          acc_ev   = 1'b0;
  logic [31:0] exp_q [$];

  function automatic void check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (dut %0d, cycle %0d)", name, act, exp, cur, cyc);
    end
  endfunction

  function automatic logic [31:0] p_ref(input logic [31:0] x);
    logic [31:0] y;
    y = 32'd0;
    for (int i = 0; i < 32; i++) begin
      y[31 - i] = x[32 - ptab[i]];
    end
    return y;
  endfunction

  function automatic logic [31:0] exp_fmt(input logic [31:0] raw);
`ifdef DES_SBOX_PERM_EN
    return p_ref(raw);
`else
    return raw;
`endif
  endfunction

  function automatic logic [31:0] ref_f(input logic [47:0] d);
    logic [31:0] raw;
    logic [5:0]  ch;
    int          row;
    int          col;
    raw = 32'd0;
    for (int b = 0; b < 8; b++) begin
      ch  = d[47 - 6 * b -: 6];
      row = int'({ch[5], ch[0]});
      col = int'(ch[4:1]);
      raw[31 - 4 * b -: 4] = 4'(sbox_ref[b * 64 + row * 16 + col]);
    end
    return exp_fmt(raw);
  endfunction

  function automatic logic [47:0] rand48();
    logic [47:0] r;
    r = {16'($urandom()), 32'($urandom())};
    return r;
  endfunction

  // One clock: scoreboard the handshakes visible now, then advance past the edge.
  task automatic tick();
    acc_ev = 1'b0;
    if (clear_in[cur] == 1'b0) begin
      if (valid_in[cur] && ready_out[cur]) begin
        exp_q.push_back(ref_f(data_in[cur]));
        acc_ev   = 1'b1;
        gap      = cyc - last_acc;
        last_acc = cyc;
      end
      if (valid_out[cur] && ready_in[cur]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_spurious: output %0h with no block outstanding (dut %0d)", data_out[cur], cur);
        end else begin
          check("sb_data", 48'(data_out[cur]), 48'(exp_q.pop_front()));
        end
      end
    end else begin
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Single block with i_ready high: checks latency, o_ready low throughout, result.
  task automatic run_block(input int idx, input logic [47:0] d, input logic [31:0] raw);
    int k;
    bit ready_low;
    cur           = idx;
    ready_in[idx] = 1'b1;
    data_in[idx]  = d;
    valid_in[idx] = 1'b1;
    k = 0;
    while (!ready_out[idx] && k < 20) begin
      tick();
      k++;
    end
    check("accept_ready", 48'(ready_out[idx]), 48'd1);
    tick();
    valid_in[idx] = 1'b0;
    k         = 0;
    ready_low = 1'b1;
    while (!valid_out[idx] && k < 20) begin
      if (ready_out[idx]) ready_low = 1'b0;
      tick();
      k++;
    end
    if (ready_out[idx]) ready_low = 1'b0;
    check("latency", 48'(k), 48'(8 >> idx));
    check("ready_low_busy", 48'(ready_low), 48'd1);
    check("result", 48'(data_out[idx]), 48'(exp_fmt(raw)));
    tick();
    check("idle_after_xfer", 48'({valid_out[idx], ready_out[idx]}), 48'd1);
  endtask

  // 1000 blocks: first half back-to-back with i_ready high, second half random i_ready.
  task automatic run_random(input int idx);
    int sent;
    int budget;
    cur           = idx;
    sent          = 0;
    budget        = 0;
    ready_in[idx] = 1'b1;
    data_in[idx]  = rand48();
    valid_in[idx] = 1'b1;
    while ((sent < 1000 || exp_q.size() != 0) && budget < 20000) begin
      if (sent >= 500) ready_in[idx] = ($urandom_range(0, 3) != 0);
      tick();
      budget++;
      if (acc_ev) begin
        // Each block spends STEPS cycles in BUSY, one in DONE and one in IDLE.
        if (sent > 0 && sent < 500) check("throughput", 48'(gap), 48'((8 >> idx) + 2));
        sent++;
        data_in[idx]  = rand48();
        valid_in[idx] = (sent < 1000);
      end
    end
    check("random_done", 48'(budget < 20000), 48'd1);
    valid_in[idx] = 1'b0;
    ready_in[idx] = 1'b1;
  endtask

  typedef struct {
    int          idx;
    logic [47:0] data;
    logic [31:0] raw;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int k;
    vecs[0] = '{3, 48'h000000000000, 32'hEFA72C4D};
    vecs[1] = '{0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[2] = '{1, 48'h041041041041, 32'h03DDEAD1};
    vecs[3] = '{2, 48'h820820820820, 32'h40DA4917};
    vecs[4] = '{3, 48'h79E79E79E79E, 32'h7A8F9B17};
    vecs[5] = '{1, 48'h000000000000, 32'hEFA72C4D};
    vecs[6] = '{0, 48'h820820820820, 32'h40DA4917};
    vecs[7] = '{2, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};

    for (int d = 0; d < 4; d++) begin
      clear_in[d] = 1'b0;
      valid_in[d] = 1'b0;
      ready_in[d] = 1'b0;
      data_in[d]  = 48'd0;
    end

    // Reset values
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      cur = d;
      check("rst_ready", 48'(ready_out[d]), 48'd1);
      check("rst_valid", 48'(valid_out[d]), 48'd0);
      check("rst_data",  48'(data_out[d]),  48'd0);
      check("rst_busy",  48'(busy_out[d]),  48'd0);
    end
    rst_n = 1'b1;
    tick();

    // Table-driven vectors
    for (int v = 0; v < 8; v++) begin
      run_block(vecs[v].idx, vecs[v].data, vecs[v].raw);
    end

    // Backpressure on LANES=2: result held 10 cycles, new input ignored
    cur          = 1;
    ready_in[1]  = 1'b0;
    data_in[1]   = 48'h041041041041;
    valid_in[1]  = 1'b1;
    tick();
    valid_in[1]  = 1'b0;
    k = 0;
    while (!valid_out[1] && k < 20) begin
      tick();
      k++;
    end
    check("bp_latency", 48'(k), 48'd4);
    for (int i = 0; i < 10; i++) begin
      data_in[1]  = 48'h820820820820;
      valid_in[1] = 1'b1;
      tick();
      check("bp_hold_valid", 48'(valid_out[1]), 48'd1);
      check("bp_hold_data",  48'(data_out[1]),  48'(exp_fmt(32'h03DDEAD1)));
      check("bp_ready_low",  48'(ready_out[1]), 48'd0);
    end
    valid_in[1] = 1'b0;
    ready_in[1] = 1'b1;
    tick();
    check("bp_release_idle", 48'({valid_out[1], ready_out[1]}), 48'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_no_capture", 48'({valid_out[1], busy_out[1]}), 48'd0);
    end

    // Clear on LANES=4 at BUSY step 1: abort, o_data keeps the previous result
    cur         = 2;
    ready_in[2] = 1'b1;
    data_in[2]  = 48'h79E79E79E79E;
    valid_in[2] = 1'b1;
    tick();
    valid_in[2] = 1'b0;
    tick();
    check("clr_busy", 48'(busy_out[2]), 48'd1);
    clear_in[2] = 1'b1;
    tick();
    clear_in[2] = 1'b0;
    check("clr_state", 48'({ready_out[2], valid_out[2], busy_out[2]}), 48'b100);
    check("clr_data",  48'(data_out[2]), 48'(exp_fmt(32'hD9CE3DCB)));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("clr_no_valid", 48'(valid_out[2]), 48'd0);
    end
    clear_in[2] = 1'b1;
    valid_in[2] = 1'b1;
    data_in[2]  = 48'hFFFFFFFFFFFF;
    tick();
    clear_in[2] = 1'b0;
    valid_in[2] = 1'b0;
    check("clr_wins", 48'({ready_out[2], busy_out[2]}), 48'b10);
    tick();
    check("clr_wins_idle", 48'(busy_out[2]), 48'd0);
    run_block(2, 48'h000000000000, 32'hEFA72C4D);

    // Asynchronous reset in the middle of BUSY on LANES=1
    cur         = 0;
    ready_in[0] = 1'b1;
    data_in[0]  = 48'hFFFFFFFFFFFF;
    valid_in[0] = 1'b1;
    tick();
    valid_in[0] = 1'b0;
    tick();
    tick();
    check("arst_pre_busy", 48'(busy_out[0]), 48'd1);
    rst_n = 1'b0;
    #2;
    check("arst_ready", 48'(ready_out[0]), 48'd1);
    check("arst_valid", 48'(valid_out[0]), 48'd0);
    check("arst_data",  48'(data_out[0]),  48'd0);
    check("arst_busy",  48'(busy_out[0]),  48'd0);
    exp_q.delete();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("arst_discarded", 48'(valid_out[0]), 48'd0);
    end

    // Random blocks against the reference model for every lane count
    for (int d = 0; d < 4; d++) begin
      run_random(d);
    end

    check("sb_empty", 48'(exp_q.size()), 48'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
